// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via trial subtraction.
// Start/busy/done handshake; results and div_by_zero hold until the next division completes.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; results from the last division are held
// S_RUN  | one shift/trial-subtract iteration per cycle, cnt counts down
// S_DONE | single-cycle done pulse; start here is accepted as in S_IDLE
module seq_restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] prem;
   logic [WIDTH-1:0] qreg;
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             dvsr_zero;
   logic             cnt_last;

   logic [WIDTH:0]   prem_shift;
   logic [WIDTH:0]   trial;
   logic             no_borrow;
   logic [WIDTH-1:0] prem_nxt;
   logic [WIDTH-1:0] qreg_nxt;

   assign accept    = start && (state != S_RUN);
   assign dvsr_zero = (divisor == '0);
   assign cnt_last  = (cnt == CW'(1));

   // The kept partial remainder is always below the divisor, so its top bit is
   // zero between iterations; only the shifted value needs the extra bit.
   always_comb begin
      prem_shift = {prem, qreg[WIDTH-1]};
      trial      = prem_shift - {1'b0, dvsr};
      no_borrow  = ~trial[WIDTH];
      prem_nxt   = no_borrow ? trial[WIDTH-1:0] : prem_shift[WIDTH-1:0];
      qreg_nxt   = {qreg[WIDTH-2:0], no_borrow};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = dvsr_zero ? S_DONE : S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (cnt_last) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prem <= '0;
         qreg <= '0;
         dvsr <= '0;
         cnt  <= '0;
      end else if (accept && !dvsr_zero) begin
         prem <= '0;
         qreg <= dividend;
         dvsr <= divisor;
         cnt  <= CW'(WIDTH);
      end else if (state == S_RUN) begin
         prem <= prem_nxt;
         qreg <= qreg_nxt;
         cnt  <= cnt - CW'(1);
      end
   end

   // Result registers move only when S_DONE is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept && dvsr_zero) begin
         quotient    <= '1;
         remainder   <= dividend;
         div_by_zero <= 1'b1;
      end else if (state == S_RUN && cnt_last) begin
         quotient    <= qreg_nxt;
         remainder   <= prem_nxt;
         div_by_zero <= 1'b0;
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: cycle-level arithmetic reference model compared every cycle,
// directed boundary cases with literal expectations, then randomized back-to-back divisions.
module tb_seq_restoring_divider;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   seq_restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 running, 2 done pulse. Results from / and %.
   int               m_phase = 0;
   int               m_left  = 0;
   logic [WIDTH-1:0] m_pq, m_pr;
   logic [WIDTH-1:0] m_q   = '0;
   logic [WIDTH-1:0] m_r   = '0;
   logic             m_dbz = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_q     = '0;
         m_r     = '0;
         m_dbz   = 1'b0;
      end else if (m_phase == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_phase = 2;
            m_q     = m_pq;
            m_r     = m_pr;
            m_dbz   = 1'b0;
         end
      end else if (start) begin
         if (divisor == 0) begin
            m_phase = 2;
            m_q     = '1;
            m_r     = dividend;
            m_dbz   = 1'b1;
         end else begin
            m_phase = 1;
            m_left  = WIDTH;
            m_pq    = dividend / divisor;
            m_pr    = dividend % divisor;
         end
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_busy", 32'(busy), 32'(m_phase == 1));
         chk("model_done", 32'(done), 32'(m_phase == 2));
         chk("model_quotient", 32'(quotient), 32'(m_q));
         chk("model_remainder", 32'(remainder), 32'(m_r));
         chk("model_dbz", 32'(div_by_zero), 32'(m_dbz));
      end
   end

   // Called away from a rising edge; returns 1 ns after the accepting edge.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) return;
      end
      chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic run_div(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic edbz, input int elat);
      int cyc;
      start_op(a, b);
      wait_done(cyc);
      chk({name, "_latency"}, 32'(cyc), 32'(elat));
      chk({name, "_q"}, 32'(quotient), 32'(eq));
      chk({name, "_r"}, 32'(remainder), 32'(er));
      chk({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
   endtask

   initial begin
      int               cyc;
      bit               saw_done;
      logic [WIDTH-1:0] a, b;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);

      run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
      repeat (3) @(negedge clk);
      chk("held_q", 32'(quotient), 32'd14);
      chk("held_r", 32'(remainder), 32'd2);

      run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
      run_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
      run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
      run_div("d200_0", 8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1);
      run_div("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9);

      // start during RUN is ignored
      start_op(8'd100, 8'd7);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(cyc);
      chk("ign_latency", 32'(cyc), 32'd5);
      chk("ign_q", 32'(quotient), 32'd14);
      chk("ign_r", 32'(remainder), 32'd2);
      run_div("b2b_50_5", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);

      // reset mid-operation
      start_op(8'd100, 8'd7);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_q", 32'(quotient), 32'd0);
      chk("mid_rst_r", 32'(remainder), 32'd0);
      chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("mid_rst_no_done", 32'(saw_done), 32'd0);
      run_div("d20_6", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 9);

      for (int n = 0; n < 150; n++) begin
         a = WIDTH'($urandom_range(0, 255));
         b = ($urandom_range(0, 9) == 0) ? 8'd0 : WIDTH'($urandom_range(1, 255));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         start_op(a, b);
         if (b != 0 && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 5)) begin
               @(posedge clk);
               #1;
            end
            start    = 1'b1;
            dividend = WIDTH'($urandom);
            divisor  = WIDTH'($urandom);
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         wait_done(cyc);
         if (b != 0) begin
            chk("inv_product", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk("inv_rem_lt_div", 32'(remainder < b), 32'd1);
         end else begin
            chk("rand_dbz_r", 32'(remainder), 32'(a));
         end
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
